ibex_bloom_ctrl: RTL



---
 rtl/ibex_pkg.sv | 33 +++
 rtl/ibex_bloom_hash.sv | 22 ++
 rtl/ibex_bloom_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ibex_pkg.sv
// +----------------------------------------------------------------------------+
// | Module  : ibex_pkg                                                         |
// | Purpose : Shared types and constants for the bloom-filter custom datapath: |
// |           op encodings, controller states and per-step hash salts.         |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package ibex_pkg;

  // custom_op encodings; any other 5-bit value is an illegal op
  typedef enum logic [4:0] {
    BLOOM_INSERT = 5'd1,
    BLOOM_CHECK  = 5'd2,
    BLOOM_CLEAR  = 5'd3
  } bloom_op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_EVAL = 3'd2,
    S_CLR  = 3'd3,
    S_RESP = 3'd4
  } bloom_state_e;

  // Salt mixed in at hash step j
  localparam logic [31:0] BLOOM_SALT [4] = '{
    32'h9E3779B9, 32'h85EBCA6B, 32'hC2B2AE35, 32'h27D4EB2F
  };

endpackage

`default_nettype wire

// File: rtl/ibex_bloom_hash.sv
// +----------------------------------------------------------------------------+
// | Module  : ibex_bloom_hash                                                  |
// | Purpose : Combinational hash step h' = rol(h,5) ^ (h >> 7) ^ SALT[j].      |
// | Ports   : h_i [31:0] current hash, j_i [1:0] step index,                   |
// |           h_o [31:0] next hash                                             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module ibex_bloom_hash
  import ibex_pkg::*;
(
  input  logic [31:0] h_i,
  input  logic [1:0]  j_i,
  output logic [31:0] h_o
);

  assign h_o = {h_i[26:0], h_i[31:27]} ^ (h_i >> 7) ^ BLOOM_SALT[j_i];

endmodule

`default_nettype wire

// File: rtl/ibex_bloom_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module  : ibex_bloom_ctrl                                                  |
// | Purpose : Sequencer for the bloom-filter custom instructions (INSERT,      |
// |           CHECK, CLEAR). Derives NUM_HASH bit indices per key and drives   |
// |           read/modify/write traffic on a single-port bit-array memory.     |
// | Ports   : clk_i, rst_i (sync, active-high)                                 |
// |           req_valid_i/req_ready_o, req_op_i[4:0], req_rs1_i, req_rs2_i     |
// |           flush_i (kill in-flight op), busy_o                              |
// |           resp_valid_o (1-cycle strobe), resp_data_o[31:0] (held)          |
// |           mem_req_o, mem_we_o, mem_addr_o[ADDR_W-1:0], mem_wdata_o,        |
// |           mem_rdata_i (valid the cycle after a read)                       |
// | Config  : IBEX_BLOOM_EARLY_EXIT_EN - CHECK ends on the first zero bit.     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module ibex_bloom_ctrl
  import ibex_pkg::*;
#(
  parameter int unsigned NUM_HASH = 3,
  parameter int unsigned ADDR_W   = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [4:0]        req_op_i,
  input  logic [31:0]       req_rs1_i,
  input  logic [31:0]       req_rs2_i,
  input  logic              flush_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_data_o,
  output logic              busy_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam logic [1:0] LAST_J = 2'(NUM_HASH - 1);

  bloom_state_e      state_q, state_d;
  logic [4:0]        op_q, op_d;
  logic [31:0]       h_q, h_d;
  logic [1:0]        j_q, j_d;
  logic [ADDR_W-1:0] c_q, c_d;
  logic              all_set_q, all_set_d;
  logic [31:0]       resp_data_q, resp_data_d;

  logic [31:0]       h_next;
  logic [ADDR_W-1:0] word_idx;
  logic [4:0]        bit_idx;
  logic              rd_bit;
  logic              result;
  logic              accept;

  ibex_bloom_hash u_hash (
    .h_i (h_q),
    .j_i (j_q),
    .h_o (h_next)
  );

  assign word_idx = h_q[ADDR_W+4:5];
  assign bit_idx  = h_q[4:0];
  assign rd_bit   = mem_rdata_i[bit_idx];
  // Only INSERT/CHECK report all_set; CLEAR and illegal ops answer 0
  assign result   = ((op_q == BLOOM_INSERT) || (op_q == BLOOM_CHECK)) & all_set_q;

  assign req_ready_o = (state_q == S_IDLE) & ~rst_i & ~flush_i;
  assign busy_o      = (state_q != S_IDLE) & ~rst_i;
  assign accept      = req_valid_i & req_ready_o;
  assign resp_data_o = rst_i        ? 32'd0 :
                       resp_valid_o ? {31'd0, result} : resp_data_q;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    h_d          = h_q;
    j_d          = j_q;
    c_d          = c_q;
    all_set_d    = all_set_q;
    resp_data_d  = resp_data_q;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = 32'd0;
    resp_valid_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d      = req_op_i;
          h_d       = req_rs1_i ^ req_rs2_i;
          j_d       = 2'd0;
          c_d       = '0;
          all_set_d = 1'b1;
          case (req_op_i)
            BLOOM_INSERT, BLOOM_CHECK: state_d = S_RD;
            BLOOM_CLEAR:               state_d = S_CLR;
            default:                   state_d = S_RESP;
          endcase
        end
      end
      S_RD: begin
        mem_req_o  = 1'b1;
        mem_addr_o = word_idx;
        state_d    = S_EVAL;
      end
      S_EVAL: begin
        all_set_d = all_set_q & rd_bit;
        if (op_q == BLOOM_INSERT) begin
          mem_req_o   = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = word_idx;
          mem_wdata_o = mem_rdata_i | (32'd1 << bit_idx);
        end
        h_d = h_next;
        if (j_q == LAST_J) begin
          state_d = S_RESP;
        end else begin
          j_d     = j_q + 2'd1;
          state_d = S_RD;
        end
`ifdef IBEX_BLOOM_EARLY_EXIT_EN
        if ((op_q == BLOOM_CHECK) && !rd_bit) begin
          state_d = S_RESP;
        end
`endif
      end
      S_CLR: begin
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = c_q;
        c_d        = c_q + 1'b1;
        if (c_q == {ADDR_W{1'b1}}) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid_o = 1'b1;
        resp_data_d  = {31'd0, result};
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A kill drops the op on the spot: nothing further reaches memory or the
    // response port, and the previously returned result stays visible.
    if (flush_i && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      resp_data_d  = resp_data_q;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = '0;
      mem_wdata_o  = 32'd0;
      resp_valid_o = 1'b0;
    end

    if (rst_i) begin
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = '0;
      mem_wdata_o  = 32'd0;
      resp_valid_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      op_q        <= 5'd0;
      h_q         <= 32'd0;
      j_q         <= 2'd0;
      c_q         <= '0;
      all_set_q   <= 1'b0;
      resp_data_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      h_q         <= h_d;
      j_q         <= j_d;
      c_q         <= c_d;
      all_set_q   <= all_set_d;
      resp_data_q <= resp_data_d;
    end
  end

endmodule

`default_nettype wire
